// File: rtl/timer_dev.sv
// ============================================================================
//  Module   : timer_dev
//  Purpose  : Memory-mapped countdown timer with a level interrupt request
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] C_OFF_CTRL   = 2'd0;
    localparam logic [1:0] C_OFF_PRESET = 2'd1;
    localparam logic [1:0] C_OFF_COUNT  = 2'd2;
    localparam logic [1:0] C_MODE_AUTO  = 2'b01;

    state_t      state_q,  state_d;
    logic [3:0]  ctrl_q,   ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q,  count_d;
    logic        irqf_q,   irqf_d;

    logic        w_en;
    logic [1:0]  w_mode;
    logic        w_im;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        unused_addr;

    assign w_en        = ctrl_q[0];
    assign w_mode      = ctrl_q[2:1];
    assign w_im        = ctrl_q[3];
    assign w_wr_ctrl   = we && (addr[3:2] == C_OFF_CTRL);
    assign w_wr_preset = we && (addr[3:2] == C_OFF_PRESET);
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irqf_d   = irqf_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (w_mode == C_MODE_AUTO) begin
                    state_d = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    irqf_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes are applied last so they override the FSM's EN/IRQF updates.
        if (w_wr_ctrl) begin
            ctrl_d = wdata[3:0];
            irqf_d = 1'b0;
        end
        if (w_wr_preset) begin
            preset_d = wdata;
            irqf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irqf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irqf_q   <= irqf_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        unique case (addr[3:2])
            C_OFF_CTRL:   rdata = {28'd0, ctrl_q};
            C_OFF_PRESET: rdata = preset_q;
            C_OFF_COUNT:  rdata = count_q;
            default:      rdata = 32'd0;
        endcase
    end

    assign irq = w_im & (irqf_q | (state_q == S_INT));

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// ============================================================================
//  Module   : tb_timer_dev
//  Purpose  : Directed and randomized self-checking bench for timer_dev
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int passed = 0;
    int total  = 0;

    timer_dev u_dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] rand_addr(input logic [1:0] off);
        logic [31:0] a;
        a      = $urandom;
        a[3:2] = off;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
        addr = rand_addr(off);
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // Called just after a falling edge; exactly one rising edge performs the write.
    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        we    = 1'b1;
        addr  = rand_addr(off);
        wdata = data;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected state j edges after the enabling CTRL write, starting from reset.
    // Each period is: LOAD, max(N,1) counting cycles, INT.
    task automatic model(input int n, input bit auto_m, input bit im, input int j,
                         output logic [31:0] cnt, output logic irq_e, output bit en_e);
        int m, o;
        m     = (n > 0) ? n : 1;
        o     = j - 1;
        cnt   = 32'd0;
        irq_e = 1'b0;
        en_e  = 1'b1;
        if (j == 0) begin
            return;
        end
        if (auto_m) begin
            o = o % (m + 2);
        end else if (o > m + 1) begin
            irq_e = im;
            en_e  = 1'b0;
            return;
        end
        if (o >= 1 && o <= m) begin
            cnt = n - (o - 1);
        end else if (o == m + 1) begin
            irq_e = im;
        end
    endtask

    initial begin
        logic [31:0] e_cnt;
        logic        e_irq;
        bit          e_en;
        int          n;
        logic [1:0]  mode;
        bit          im;

        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state and ignored writes
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_preset", 2'd1, 32'd0);
        rd("rst_count", 2'd2, 32'd0);
        rd("rst_rsvd", 2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);
        wr(2'd2, 32'd5);
        rd("count_ro", 2'd2, 32'd0);
        wr(2'd3, 32'hDEAD_BEEF);
        rd("rsvd_ro", 2'd3, 32'd0);

        // One-shot, N=3
        wr(2'd1, 32'd3);
        rd("preset_rd", 2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(2);
        rd("os_cnt_e2", 2'd2, 32'd3);
        tick(1);
        rd("os_cnt_e3", 2'd2, 32'd2);
        tick(1);
        rd("os_cnt_e4", 2'd2, 32'd1);
        chk_irq("os_irq_e4", 1'b0);
        tick(1);
        rd("os_cnt_e5", 2'd2, 32'd0);
        chk_irq("os_irq_e5", 1'b1);
        tick(1);
        rd("os_ctrl_e6", 2'd0, 32'h8);
        chk_irq("os_irq_e6", 1'b1);
        tick(3);
        chk_irq("os_irq_hold", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload, N=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int j = 1; j <= 12; j++) begin
            tick(1);
            model(2, 1'b1, 1'b1, j, e_cnt, e_irq, e_en);
            rd($sformatf("ar_cnt_%0d", j), 2'd2, e_cnt);
            chk_irq($sformatf("ar_irq_%0d", j), e_irq);
        end
        rd("ar_ctrl", 2'd0, 32'hB);
        wr(2'd0, 32'h0);
        tick(4);

        // Masked expiry
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick(4);
        rd("mask_cnt", 2'd2, 32'd0);
        chk_irq("mask_irq_int", 1'b0);
        tick(1);
        rd("mask_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_irqf_clr", 1'b0);
        tick(2);
        chk_irq("mask_irqf_clr2", 1'b0);

        // Pause at COUNT=6
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        rd("pause_cnt7", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        rd("pause_cnt6", 2'd2, 32'd6);
        tick(4);
        rd("pause_frozen", 2'd2, 32'd6);
        chk_irq("pause_irq", 1'b0);

        // PRESET=0 expires after E+3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_irq("p0_irq_e2", 1'b0);
        tick(1);
        chk_irq("p0_irq_e3", 1'b1);
        rd("p0_cnt_e3", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("p0_clr", 1'b0);

        // CTRL write colliding with the one-shot INT edge
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(5);
        chk_irq("col_int", 1'b1);
        wr(2'd0, 32'hB);
        rd("col_ctrl", 2'd0, 32'hB);
        chk_irq("col_irqf", 1'b0);
        tick(2);
        rd("col_reload", 2'd2, 32'd3);
        wr(2'd0, 32'h0);
        tick(4);

        // Reset mid-count
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        rd("mid_cnt7", 2'd2, 32'd7);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd("mr_ctrl", 2'd0, 32'd0);
        rd("mr_preset", 2'd1, 32'd0);
        rd("mr_count", 2'd2, 32'd0);
        chk_irq("mr_irq", 1'b0);

        // Randomized trials against the period model
        for (int t = 0; t < 10; t++) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            n    = $urandom_range(0, 12);
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            wr(2'd1, n);
            wr(2'd0, {28'd0, im, mode, 1'b1});
            for (int j = 1; j <= 3 * (n + 3) + 2; j++) begin
                tick(1);
                model(n, mode == 2'b01, im, j, e_cnt, e_irq, e_en);
                rd($sformatf("rnd%0d_cnt_%0d", t, j), 2'd2, e_cnt);
                chk_irq($sformatf("rnd%0d_irq_%0d", t, j), e_irq);
                rd($sformatf("rnd%0d_ctrl_%0d", t, j), 2'd0, {28'd0, im, mode, e_en});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that acts as the responder on the data-memory bus driven by the MEM stage. It decodes word-addressed loads and stores from the CPU through the bridge, keeps three architectural registers (CTRL, PRESET, COUNT), runs a 4-state countdown FSM, and raises an interrupt request toward the CPU on expiry. Read data is combinational so the MEM stage can capture it into its MEM/WB pipeline register in the same cycle.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state on the clock edge.
- we  input  1  write strobe from bridge; already qualified by device select.
- addr  input  32  byte address; only addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved); addr[1:0] and addr[31:4] ignored.
- wdata  input  32  store data.
- rdata  output  32  combinational read of register at addr[3:2].
- irq  output  1  interrupt request, level, combinational from state.

## Operation
- CTRL[0] EN, CTRL[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), CTRL[3] IM (irq mask, 1 = enabled). CTRL[31:4] read 0, not stored.
- PRESET: 32-bit reload value, R/W. COUNT: 32-bit, read-only; writes ignored. Reserved offset reads 0, writes ignored.
- Write to CTRL or PRESET clears the sticky flag IRQF.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: EN=0 -> IDLE (COUNT frozen); else COUNT > 1 -> COUNT-1, stay; else (COUNT <= 1) COUNT <= 0, -> INT.
  - INT: MODE one-shot -> clear EN, set IRQF, -> IDLE. MODE auto-reload -> -> LOAD, IRQF unchanged.
- irq = IM & (IRQF | (state == INT)). One-shot: irq held from INT until CTRL/PRESET write or IM=0. Auto-reload: one-cycle pulse per period.
- FSM decisions use register values before the current-edge write. A CTRL write in the same cycle the FSM clears EN (INT, one-shot) wins: CTRL takes wdata[3:0]; IRQF is still cleared by that write (the write wins over the set).
- PRESET=0: LOAD loads 0, CNT goes straight to INT next edge.
- Decrement is plain 32-bit unsigned; no wrap because COUNT <= 1 terminates.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, IRQF=0, state=IDLE, irq=0; rdata follows addr (reads 0 for all offsets after reset).
- rdata: zero-latency combinational; reflects the register value before the current edge's write.
- Writes: visible on rdata the cycle after the write edge.
- EN written at edge E: LOAD after E+1, COUNT=PRESET=N after E+2, COUNT=N-k after E+2+k, COUNT=0 and state INT after E+2+N (N>=1); irq high from that cycle.
- Auto-reload period: N+2 cycles (INT, LOAD, N CNT cycles), irq high 1 cycle per period.
- Reset mid-count: everything returns to reset values at that edge; irq drops immediately after.

## Test plan
- Reset: after reset, read CTRL/PRESET/COUNT/offset3 -> all 0, irq=0; write COUNT=5 -> COUNT still reads 0.
- One-shot: PRESET=3, then CTRL=0x9 at edge E -> COUNT reads 3,2,1 after E+2..E+4, 0 and irq=1 after E+5; CTRL reads 0x8 after E+6; irq stays 1 until CTRL write 0x8 -> irq=0 next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> irq pulses 1 cycle, period 4 cycles, COUNT sequence 2,1,0,(LOAD)2,...; CTRL stays 0xB.
- Mask: PRESET=2, CTRL=0x1 -> expiry with irq=0; then CTRL=0x8 -> IRQF cleared by write, irq stays 0.
- Pause/edge cases: PRESET=10, EN, clear EN mid-count at COUNT=6 -> COUNT frozen at 6 and state IDLE; PRESET=0 with CTRL=0x9 -> irq after E+3.
- Collision/reset: CTRL write 0xB on the INT edge of a one-shot -> CTRL reads 0xB, IRQF=0; reset asserted with COUNT=7 -> all reads 0, irq=0 next cycle.
